// File: rtl/rv32i_pkg.sv
// Shared RV32I fetch definitions: data width, reset vector, NOP encoding,
// fetch FSM state type and the {pc,instr} queue entry layout.
package rv32i_pkg;

    localparam int unsigned XLEN                 = 32;
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INSTR_NOP            = 32'h0000_0013;

    typedef enum logic [1:0] {
        ISSUE   = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch stage bus bundle: PC register link, instruction memory request and
// response, redirect input and the decode handshake.
// master = fetch stage side, slave = surrounding pipeline / memory side.
interface fetch_unit_if;
    import rv32i_pkg::*;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcNext;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            dec_valid;
    logic            dec_ready;
    logic [XLEN-1:0] dec_instr;
    logic [XLEN-1:0] dec_pc;

    modport master (
        input  pc,
        output pcNext,
        output imem_req_valid,
        input  imem_req_ready,
        output imem_addr,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        input  redirect_valid,
        input  redirect_pc,
        output dec_valid,
        input  dec_ready,
        output dec_instr,
        output dec_pc
    );

    modport slave (
        output pc,
        input  pcNext,
        input  imem_req_valid,
        output imem_req_ready,
        input  imem_addr,
        output imem_rsp_valid,
        output imem_rsp_data,
        output redirect_valid,
        output redirect_pc,
        input  dec_valid,
        output dec_ready,
        input  dec_instr,
        input  dec_pc
    );

endinterface

// File: rtl/fetch_queue.sv
// QDEPTH-entry FIFO of fetch entries with push, pop, flush and occupancy.
// Flush wins over a same-cycle push; push+pop when full keeps count.
module fetch_queue
    import rv32i_pkg::*;
#(
    parameter int unsigned QDEPTH = 2,
    localparam int unsigned AW    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [AW:0]  count
);

    fetch_entry_t      mem_q [QDEPTH];
    fetch_entry_t      mem_d [QDEPTH];
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]       count_q, count_d;

    // Next pointers, count and storage; power-of-two depth makes pointers wrap naturally
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Register queue state
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: one-outstanding-request fetch FSM, pcNext mux and a
// fetch queue toward decode. Optional macro FETCH_STALL_CNT_EN adds
// stall_cnt, counting cycles where decode is ready but nothing is offered.
module fetch_unit
    import rv32i_pkg::*;
#(
    parameter int unsigned QDEPTH       = 2,
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    fetch_unit_if.master      io
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [XLEN-1:0]   stall_cnt
`endif
);

    localparam int unsigned AW    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [AW:0] QFULL = (AW+1)'(QDEPTH);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            req_valid, accept, push, pop, dec_valid;
    logic [AW:0]     q_count;
    fetch_entry_t    q_head, q_push_data;

    fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (q_push_data),
        .pop       (pop),
        .flush     (io.redirect_valid),
        .head      (q_head),
        .count     (q_count)
    );

    // Handshakes, FSM next state and pcNext selection; redirect overrides everything
    always_comb begin
        dec_valid   = !reset && (q_count != '0);
        req_valid   = !reset && (state_q == ISSUE) && (q_count < QFULL) && !io.redirect_valid;
        accept      = req_valid && io.imem_req_ready;
        push        = !reset && (state_q == WAIT) && io.imem_rsp_valid && !io.redirect_valid;
        pop         = dec_valid && io.dec_ready && !io.redirect_valid;
        q_push_data = '{pc: req_pc_q, instr: io.imem_rsp_data};
        req_pc_d    = accept ? io.pc : req_pc_q;
        state_d     = state_q;

        unique case (state_q)
            ISSUE:   if (accept) state_d = WAIT;
            WAIT:    if (io.imem_rsp_valid) state_d = ISSUE;
                     else if (io.redirect_valid) state_d = DISCARD;
            DISCARD: if (io.imem_rsp_valid) state_d = ISSUE;
            default: state_d = ISSUE;
        endcase

        if (reset)                  io.pcNext = RESET_VECTOR;
        else if (io.redirect_valid) io.pcNext = io.redirect_pc;
        else if (accept)            io.pcNext = io.pc + 32'd4;
        else                        io.pcNext = io.pc;

        io.imem_req_valid = req_valid;
        io.dec_valid      = dec_valid;
        io.dec_instr      = q_head.instr;
        io.dec_pc         = q_head.pc;
    end

    assign io.imem_addr = io.pc;

    // Fetch FSM state and in-flight request pc
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ISSUE;
            req_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            req_pc_q <= req_pc_d;
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic [XLEN-1:0] stall_cnt_q, stall_cnt_d;

    // Count decode-starved cycles
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (io.dec_ready && !dec_valid) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    // Register stall counter
    always_ff @(posedge clk) begin
        if (reset) stall_cnt_q <= '0;
        else       stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit. The bench acts as the PC
// register (pc <= pcNext each cycle) and, when auto_rsp is set, as a
// one-cycle-latency instruction memory returning instr_of(addr).
module tb_fetch_unit;
    import rv32i_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic auto_rsp;
`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    fetch_unit_if io ();

    fetch_unit #(.QDEPTH(2), .RESET_VECTOR(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (io.master)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[23:0], 8'h13};
    endfunction

    task automatic tick();
        logic [31:0] nxt, aaddr;
        logic        acc;
        #1;
        nxt   = io.pcNext;
        acc   = io.imem_req_valid && io.imem_req_ready;
        aaddr = io.imem_addr;
        @(posedge clk);
        #1;
        io.pc = nxt;
        if (auto_rsp) begin
            io.imem_rsp_valid = acc;
            io.imem_rsp_data  = acc ? instr_of(aaddr) : 32'h0;
        end
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        auto_rsp = 1'b0;
        io.pc = 32'h0; io.imem_req_ready = 1'b0; io.imem_rsp_valid = 1'b0;
        io.imem_rsp_data = 32'h0; io.redirect_valid = 1'b0; io.redirect_pc = 32'h0;
        io.dec_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        auto_rsp = 1'b0;
        io.pc = 32'h55; io.imem_req_ready = 1'b1; io.imem_rsp_valid = 1'b0;
        io.imem_rsp_data = 32'h0; io.redirect_valid = 1'b0; io.redirect_pc = 32'h0;
        io.dec_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (io.pcNext !== 32'h0) begin errors++; $display("FAIL reset_pcnext c%0d: got %h expected 00000000", c, io.pcNext); end
            checks++;
            if (io.dec_valid !== 1'b0) begin errors++; $display("FAIL reset_dec_valid c%0d: got %b expected 0", c, io.dec_valid); end
            checks++;
            if (io.imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid c%0d: got %b expected 0", c, io.imem_req_valid); end
            io.pc = 32'h55;
            tick();
        end
        reset = 1'b0;
        io.imem_req_ready = 1'b0;
        io.pc = 32'h80;
        #1;
        checks++;
        if (io.imem_req_valid !== 1'b1) begin errors++; $display("FAIL post_reset_issue: got %b expected 1", io.imem_req_valid); end
        checks++;
        if (io.pcNext !== 32'h80) begin errors++; $display("FAIL post_reset_hold: got %h expected 00000080", io.pcNext); end
    endtask

    task automatic test_sequential();
        logic [31:0] epc;
        apply_reset();
        io.pc = 32'h100; io.imem_req_ready = 1'b1; io.dec_ready = 1'b1; auto_rsp = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (c >= 2 && (c % 2) == 0) begin
                epc = 32'h100 + 32'(4 * ((c - 2) / 2));
                checks++;
                if (io.dec_valid !== 1'b1) begin errors++; $display("FAIL seq_valid c%0d: got %b expected 1", c, io.dec_valid); end
                checks++;
                if (io.dec_pc !== epc) begin errors++; $display("FAIL seq_pc c%0d: got %h expected %h", c, io.dec_pc, epc); end
                checks++;
                if (io.dec_instr !== instr_of(epc)) begin errors++; $display("FAIL seq_instr c%0d: got %h expected %h", c, io.dec_instr, instr_of(epc)); end
            end else begin
                checks++;
                if (io.dec_valid !== 1'b0) begin errors++; $display("FAIL seq_idle c%0d: got %b expected 0", c, io.dec_valid); end
            end
            tick();
        end
    endtask

    task automatic test_queue_full();
        apply_reset();
        io.pc = 32'h300; io.imem_req_ready = 1'b1; io.dec_ready = 1'b0; auto_rsp = 1'b1;
        repeat (4) tick();
        checks++;
        if (io.imem_req_valid !== 1'b0) begin errors++; $display("FAIL full_req_valid: got %b expected 0", io.imem_req_valid); end
        checks++;
        if (io.pcNext !== 32'h308) begin errors++; $display("FAIL full_pcnext: got %h expected 00000308", io.pcNext); end
        checks++;
        if (io.dec_pc !== 32'h300) begin errors++; $display("FAIL full_head: got %h expected 00000300", io.dec_pc); end
        tick();
        checks++;
        if (io.imem_req_valid !== 1'b0) begin errors++; $display("FAIL full_still_blocked: got %b expected 0", io.imem_req_valid); end
        io.dec_ready = 1'b1;
        tick();
        io.dec_ready = 1'b0;
        #1;
        checks++;
        if (io.imem_req_valid !== 1'b1) begin errors++; $display("FAIL full_reissue: got %b expected 1", io.imem_req_valid); end
        checks++;
        if (io.imem_addr !== 32'h308) begin errors++; $display("FAIL full_reissue_addr: got %h expected 00000308", io.imem_addr); end
        checks++;
        if (io.dec_pc !== 32'h304) begin errors++; $display("FAIL full_new_head: got %h expected 00000304", io.dec_pc); end
        tick();
        checks++;
        if (io.imem_req_valid !== 1'b0) begin errors++; $display("FAIL full_single_req: got %b expected 0", io.imem_req_valid); end
        tick();
        checks++;
        if (io.imem_req_valid !== 1'b0) begin errors++; $display("FAIL full_refilled: got %b expected 0", io.imem_req_valid); end
    endtask

    task automatic test_redirect_wait();
        apply_reset();
        io.pc = 32'h400; io.imem_req_ready = 1'b1; io.dec_ready = 1'b0; auto_rsp = 1'b1;
        tick();
        tick();
        auto_rsp = 1'b0;
        tick();
        io.imem_rsp_valid = 1'b0;
        io.redirect_valid = 1'b1; io.redirect_pc = 32'h200; io.dec_ready = 1'b1;
        #1;
        checks++;
        if (io.pcNext !== 32'h200) begin errors++; $display("FAIL rw_pcnext: got %h expected 00000200", io.pcNext); end
        checks++;
        if (io.dec_valid !== 1'b1 || io.dec_pc !== 32'h400) begin errors++; $display("FAIL rw_preflush_head: got v=%b pc=%h expected v=1 pc=00000400", io.dec_valid, io.dec_pc); end
        tick();
        io.redirect_valid = 1'b0;
        #1;
        checks++;
        if (io.dec_valid !== 1'b0) begin errors++; $display("FAIL rw_flushed: got %b expected 0", io.dec_valid); end
        checks++;
        if (io.imem_req_valid !== 1'b0) begin errors++; $display("FAIL rw_discard_noreq: got %b expected 0", io.imem_req_valid); end
        tick();
        io.imem_rsp_valid = 1'b1; io.imem_rsp_data = 32'hDEADBEEF;
        #1;
        checks++;
        if (io.imem_req_valid !== 1'b0) begin errors++; $display("FAIL rw_discard_rsp: got %b expected 0", io.imem_req_valid); end
        tick();
        io.imem_rsp_valid = 1'b0;
        auto_rsp = 1'b1;
        #1;
        checks++;
        if (io.dec_valid !== 1'b0) begin errors++; $display("FAIL rw_dropped: got %b expected 0", io.dec_valid); end
        checks++;
        if (io.imem_req_valid !== 1'b1 || io.imem_addr !== 32'h200) begin errors++; $display("FAIL rw_reissue: got v=%b a=%h expected v=1 a=00000200", io.imem_req_valid, io.imem_addr); end
        tick();
        tick();
        checks++;
        if (io.dec_valid !== 1'b1 || io.dec_pc !== 32'h200 || io.dec_instr !== instr_of(32'h200)) begin
            errors++; $display("FAIL rw_new_head: got v=%b pc=%h i=%h expected v=1 pc=00000200 i=%h", io.dec_valid, io.dec_pc, io.dec_instr, instr_of(32'h200));
        end
    endtask

    task automatic test_redirect_rsp();
        apply_reset();
        io.pc = 32'h500; io.imem_req_ready = 1'b1; io.dec_ready = 1'b0;
        tick();
        io.imem_rsp_valid = 1'b1; io.imem_rsp_data = 32'h1111_1111;
        io.redirect_valid = 1'b1; io.redirect_pc = 32'h200;
        #1;
        checks++;
        if (io.pcNext !== 32'h200) begin errors++; $display("FAIL rr_pcnext: got %h expected 00000200", io.pcNext); end
        tick();
        io.imem_rsp_valid = 1'b0; io.redirect_valid = 1'b0;
        #1;
        checks++;
        if (io.dec_valid !== 1'b0) begin errors++; $display("FAIL rr_no_push: got %b expected 0", io.dec_valid); end
        checks++;
        if (io.imem_req_valid !== 1'b1 || io.imem_addr !== 32'h200) begin errors++; $display("FAIL rr_next_req: got v=%b a=%h expected v=1 a=00000200", io.imem_req_valid, io.imem_addr); end
        io.redirect_valid = 1'b1; io.redirect_pc = 32'h600;
        #1;
        checks++;
        if (io.imem_req_valid !== 1'b0 || io.pcNext !== 32'h600) begin errors++; $display("FAIL rr_issue_redirect: got v=%b n=%h expected v=0 n=00000600", io.imem_req_valid, io.pcNext); end
        tick();
        io.redirect_valid = 1'b0;
        #1;
        checks++;
        if (io.imem_req_valid !== 1'b1 || io.imem_addr !== 32'h600) begin errors++; $display("FAIL rr_issue_after: got v=%b a=%h expected v=1 a=00000600", io.imem_req_valid, io.imem_addr); end
    endtask

    task automatic test_pc_wrap();
        apply_reset();
        io.pc = 32'hFFFF_FFFC; io.imem_req_ready = 1'b1;
        #1;
        checks++;
        if (io.pcNext !== 32'h0) begin errors++; $display("FAIL pc_wrap: got %h expected 00000000", io.pcNext); end
    endtask

`ifdef FETCH_STALL_CNT_EN
    task automatic test_stall_cnt();
        apply_reset();
        checks++;
        if (stall_cnt !== 32'd0) begin errors++; $display("FAIL stall_reset: got %0d expected 0", stall_cnt); end
        io.dec_ready = 1'b1;
        repeat (5) tick();
        checks++;
        if (stall_cnt !== 32'd5) begin errors++; $display("FAIL stall_count: got %0d expected 5", stall_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_sequential();
        test_queue_full();
        test_redirect_wait();
        test_redirect_rsp();
        test_pc_wrap();
`ifdef FETCH_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
